xgemac_wb_master: RTL
=====================

Name: xgemac_wb_master

Overview:
Wishbone classic-cycle master that drives the XGEMAC management/configuration port.
- Accepts single register read/write commands from a testbench or config controller over a valid/ready channel.
- Runs exactly one Wishbone transfer per command and returns read data and status over a response channel.
- Sits directly upstream of the XGEMAC Wishbone slave port.
- Also conditions the MAC interrupt output into a sticky pending flag.

Parameters:
ADDR_WIDTH, 8, Wishbone address width (matches XGEMAC WB address width)
DATA_WIDTH, 32, Wishbone data width
TIMEOUT_CYCLES, 255, max cycles STB may stay high without ACK (used only with the optional feature); legal range 1..65535

Ports:
clk  input  1  single clock; all logic on posedge
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at posedge
cmd_we  input  1  1 = write, 0 = read
cmd_adr  input  ADDR_WIDTH  register address
cmd_dat  input  DATA_WIDTH  write data
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed when rsp_valid && rsp_ready at posedge
rsp_dat  output  DATA_WIDTH  read data (0 for writes)
rsp_err  output  1  1 = transfer timed out
wb_adr_o  output  ADDR_WIDTH  to MAC wb_adr_i
wb_dat_o  output  DATA_WIDTH  to MAC wb_dat_i
wb_we_o  output  1  to MAC wb_we_i
wb_cyc_o  output  1  to MAC wb_cyc_i
wb_stb_o  output  1  to MAC wb_stb_i
wb_ack_i  input  1  from MAC wb_ack_o
wb_dat_i  input  DATA_WIDTH  from MAC wb_dat_o
wb_int_i  input  1  from MAC wb_int_o
int_clr  input  1  clears int_pending
int_pending  output  1  sticky interrupt flag

Behaviour:
- Reset values (every output, registered): cmd_ready=0 during rst, then 1 in IDLE. rsp_valid=0, rsp_dat=0, rsp_err=0, wb_cyc_o=0, wb_stb_o=0, wb_we_o=0, wb_adr_o=0, wb_dat_o=0, int_pending=0. State=IDLE.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready=1.
  - On accept, latch we/adr/dat into wb_*_o, set wb_cyc_o=wb_stb_o=1 at the same edge, go to BUS.
  - Bus is active the cycle after the accept.
- BUS:
  - cmd_ready=0; cyc/stb/adr/dat/we held stable.
  - When wb_ack_i is sampled 1: drop cyc/stb at that edge.
  - Capture rsp_dat = wb_dat_i for reads, 0 for writes; rsp_err=0; rsp_valid=1; go to RESP.
  - Minimum command-accept to rsp_valid latency = 2 cycles (slave acks in its first STB cycle).
- RESP:
  - rsp_valid, rsp_dat and rsp_err held until rsp_ready.
  - On handshake: rsp_valid=0, go to IDLE. cmd_ready returns the following cycle (no accept in the same cycle as the response handshake).
- Acknowledge handling:
  - wb_ack_i outside BUS is ignored.
  - Exactly one transfer per command: no pipelining, no bursts.
- Interrupt flag:
  - wb_int_i is registered once; its rising edge (int_q==0 and wb_int_i==1) sets int_pending.
  - int_clr=1 clears int_pending.
  - Rising edge and int_clr in the same cycle: set wins, int_pending=1.
  - int_pending does not depend on FSM state.
- Reset mid-transfer: at the first posedge with rst=1, cyc/stb drop and the FSM returns to IDLE. Any pending response and int_pending are discarded.

Optional Feature:
Macro: XGEMAC_WB_TIMEOUT_EN
- Defined:
  - A 16-bit counter clears on entering BUS and increments each BUS cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES with wb_ack_i=0: drop cyc/stb, rsp_dat=0, rsp_err=1, rsp_valid=1, go to RESP.
  - Ack in the same cycle the limit is reached: ack wins, rsp_err=0.
- Not defined:
  - No counter; BUS waits for ack indefinitely.
  - rsp_err is tied to 0.

Test Plan:
1. Reset, then write adr=0x00 dat=0x0000_0005; slave acks in 1st STB cycle -> cyc/stb high exactly 1 cycle, wb_we_o=1, rsp_valid 2 cycles after accept, rsp_err=0, rsp_dat=0.
2. Read adr=0x08; slave returns 0xDEAD_BEEF after 3 wait states -> cyc/stb high 4 cycles with adr stable, rsp_dat=0xDEAD_BEEF.
3. rsp_ready held low 5 cycles after a read -> rsp_valid/rsp_dat stable; cmd_ready=0 throughout; new cmd accepted 1 cycle after the handshake.
4. wb_int_i rises while int_clr=1 in that cycle -> int_pending=1. A later int_clr alone -> 0. wb_int_i held high -> no re-set.
5. With XGEMAC_WB_TIMEOUT_EN, TIMEOUT_CYCLES=4, slave never acks -> stb high 4 cycles then drops, rsp_err=1, rsp_dat=0. Repeat with ack on the 4th cycle -> rsp_err=0.
6. rst asserted for 1 cycle during the wait states of case 2 -> cyc/stb=0 next cycle, rsp_valid never asserts, cmd_ready=1 after rst drops.

Source files
------------

// File: rtl/xgemac_wb_master.sv
// ---------------------------------------------------------------------------
// xgemac_wb_master
//
// Wishbone classic-cycle master for the XGEMAC management/configuration port.
// It takes one register read or write command at a time and runs exactly one
// Wishbone transfer for it. It then returns the read data and the status on a
// response channel. It also turns the MAC interrupt line into a sticky
// pending flag.
//
// Optional feature macro: XGEMAC_WB_TIMEOUT_EN
//   When this macro is defined, a transfer that gets no ACK within
//   TIMEOUT_CYCLES strobe cycles is abandoned and reported with rsp_err=1.
//   When it is undefined, the bus waits for ACK forever and rsp_err is
//   always 0.
//
// Ports:
//   clk, rst          single clock; synchronous active-high reset
//   cmd_*             command channel (valid/ready); we, adr, dat
//   rsp_*             response channel (valid/ready); dat, err
//   wb_*_o / wb_*_i   Wishbone master side, wired to the MAC slave port
//   wb_int_i          MAC interrupt output
//   int_clr           clears int_pending
//   int_pending       sticky flag, set on a rising edge of wb_int_i
// ---------------------------------------------------------------------------
module xgemac_wb_master #(
   parameter int ADDR_WIDTH     = 8,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_we,
   input  logic [ADDR_WIDTH-1:0] cmd_adr,
   input  logic [DATA_WIDTH-1:0] cmd_dat,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_dat,
   output logic                  rsp_err,
   output logic [ADDR_WIDTH-1:0] wb_adr_o,
   output logic [DATA_WIDTH-1:0] wb_dat_o,
   output logic                  wb_we_o,
   output logic                  wb_cyc_o,
   output logic                  wb_stb_o,
   input  logic                  wb_ack_i,
   input  logic [DATA_WIDTH-1:0] wb_dat_i,
   input  logic                  wb_int_i,
   input  logic                  int_clr,
   output logic                  int_pending
);

   // A bad limit would leave the timeout counter unable to reach it.
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("xgemac_wb_master: TIMEOUT_CYCLES must be in 1..65535");
   end

   typedef enum logic [1:0] {
      IDLE,
      BUS,
      RESP
   } state_t;

   state_t                  state_q, state_d;
   logic                    cmd_ready_q, cmd_ready_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]   rsp_dat_q, rsp_dat_d;
   logic [ADDR_WIDTH-1:0]   wb_adr_q, wb_adr_d;
   logic [DATA_WIDTH-1:0]   wb_dat_q, wb_dat_d;
   logic                    wb_we_q, wb_we_d;
   logic                    wb_cyc_q, wb_cyc_d;
   logic                    wb_stb_q, wb_stb_d;
   logic                    int_q, int_d;
   logic                    int_pending_q, int_pending_d;

`ifdef XGEMAC_WB_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
   logic [15:0]             timeout_cnt_q, timeout_cnt_d;
   logic                    rsp_err_q, rsp_err_d;
`endif

   always_comb begin
      state_d     = state_q;
      rsp_valid_d = rsp_valid_q;
      rsp_dat_d   = rsp_dat_q;
      wb_adr_d    = wb_adr_q;
      wb_dat_d    = wb_dat_q;
      wb_we_d     = wb_we_q;
      wb_cyc_d    = wb_cyc_q;
      wb_stb_d    = wb_stb_q;
`ifdef XGEMAC_WB_TIMEOUT_EN
      timeout_cnt_d = timeout_cnt_q;
      rsp_err_d     = rsp_err_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               wb_adr_d = cmd_adr;
               wb_dat_d = cmd_dat;
               wb_we_d  = cmd_we;
               wb_cyc_d = 1'b1;
               wb_stb_d = 1'b1;
               state_d  = BUS;
`ifdef XGEMAC_WB_TIMEOUT_EN
               timeout_cnt_d = '0;
`endif
            end
         end
         BUS: begin
            // If ACK arrives on the cycle the limit is reached, the ACK wins.
            if (wb_ack_i) begin
               wb_cyc_d    = 1'b0;
               wb_stb_d    = 1'b0;
               rsp_dat_d   = wb_we_q ? '0 : wb_dat_i;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
`ifdef XGEMAC_WB_TIMEOUT_EN
               rsp_err_d   = 1'b0;
            end else if (timeout_cnt_q + 16'd1 == TIMEOUT_LIMIT) begin
               // This is the last strobe cycle allowed without an ACK.
               wb_cyc_d    = 1'b0;
               wb_stb_d    = 1'b0;
               rsp_dat_d   = '0;
               rsp_err_d   = 1'b1;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else begin
               timeout_cnt_d = timeout_cnt_q + 16'd1;
`endif
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // cmd_ready is a registered copy of "next state is IDLE". It therefore
      // rises one cycle after a response handshake, never on the same cycle.
      cmd_ready_d = (state_d == IDLE);

      // A rising edge of the interrupt beats a simultaneous clear.
      int_d = wb_int_i;
      if (wb_int_i && !int_q) begin
         int_pending_d = 1'b1;
      end else if (int_clr) begin
         int_pending_d = 1'b0;
      end else begin
         int_pending_d = int_pending_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cmd_ready_q   <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_dat_q     <= '0;
         wb_adr_q      <= '0;
         wb_dat_q      <= '0;
         wb_we_q       <= 1'b0;
         wb_cyc_q      <= 1'b0;
         wb_stb_q      <= 1'b0;
         int_q         <= 1'b0;
         int_pending_q <= 1'b0;
`ifdef XGEMAC_WB_TIMEOUT_EN
         timeout_cnt_q <= '0;
         rsp_err_q     <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         cmd_ready_q   <= cmd_ready_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_dat_q     <= rsp_dat_d;
         wb_adr_q      <= wb_adr_d;
         wb_dat_q      <= wb_dat_d;
         wb_we_q       <= wb_we_d;
         wb_cyc_q      <= wb_cyc_d;
         wb_stb_q      <= wb_stb_d;
         int_q         <= int_d;
         int_pending_q <= int_pending_d;
`ifdef XGEMAC_WB_TIMEOUT_EN
         timeout_cnt_q <= timeout_cnt_d;
         rsp_err_q     <= rsp_err_d;
`endif
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_dat     = rsp_dat_q;
   assign wb_adr_o    = wb_adr_q;
   assign wb_dat_o    = wb_dat_q;
   assign wb_we_o     = wb_we_q;
   assign wb_cyc_o    = wb_cyc_q;
   assign wb_stb_o    = wb_stb_q;
   assign int_pending = int_pending_q;
`ifdef XGEMAC_WB_TIMEOUT_EN
   assign rsp_err     = rsp_err_q;
`else
   assign rsp_err     = 1'b0;
`endif

endmodule
